cover_toggle_collector: RTL

// Receiving end of the toggle-coverage hit stream. Accepts one cover index per cycle from the
// per-signal toggle points (via their serializer), keeps a sticky COVER_TOTAL-bit coverage

---
 rtl/cover_pkg.sv | 40 ++++
 rtl/cover_bitmap_sdp_ram.sv | 26 ++
 rtl/cover_toggle_collector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cover_pkg.sv
// cover_pkg: shared sizing, FSM state encoding and hit decode for the toggle
// coverage collector.
//   COVER_TOTAL  number of toggle cover points (valid indices 0..COVER_TOTAL-1)
//   WORD_W       bitmap RAM word width
//   IDX_W        hit index / covered count width
//   NUM_WORDS    bitmap RAM depth
//   ADDR_W       RAM / dump address width
//   BIT_W        bit-select width within one word
package cover_pkg;

  localparam int COVER_TOTAL = 8744;
  localparam int WORD_W      = 64;
  localparam int IDX_W       = $clog2(COVER_TOTAL);
  localparam int NUM_WORDS   = (COVER_TOTAL + WORD_W - 1) / WORD_W;
  localparam int ADDR_W      = $clog2(NUM_WORDS);
  localparam int BIT_W       = $clog2(WORD_W);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } cov_state_t;

  // One hit split into RAM word / bit; oob marks indices past the last point.
  typedef struct packed {
    logic              oob;
    logic [ADDR_W-1:0] word;
    logic [BIT_W-1:0]  bsel;
  } hit_req_t;

  function automatic hit_req_t decode_hit(input logic [IDX_W-1:0] idx);
    hit_req_t r;
    r.oob  = (idx >= IDX_W'(COVER_TOTAL));
    r.word = idx[IDX_W-1:BIT_W];
    r.bsel = idx[BIT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/cover_bitmap_sdp_ram.sv
// cover_bitmap_sdp_ram: simple dual-port bitmap storage, NUM_WORDS x WORD_W.
//   clock        write and read clock
//   we/waddr/wdata  write port
//   re/raddr     read request; rdata valid one cycle later and held until the
//                next read. A read to the address being written in the same
//                cycle returns the old word.
module cover_bitmap_sdp_ram
  import cover_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [NUM_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: receives toggle-coverage hit indices, keeps a sticky
// coverage bitmap in RAM, counts distinct points covered and dumps the bitmap
// over a valid/ready stream.
//   clock, reset            clock, asynchronous active-high reset
//   hit_valid/hit_index     incoming hit; taken when hit_ready is high
//   hit_ready               high only while collecting (RUN)
//   clear_req               pulse: zero bitmap, counter and err_oob
//   dump_req                pulse: dump the bitmap (honoured in RUN only)
//   dump_valid/dump_ready   dump stream handshake
//   dump_addr/dump_data     word index and bitmap word
//   dump_last               marks word NUM_WORDS-1
//   covered_cnt             distinct points covered
//   new_hit                 one-cycle pulse on first recording of a point
//   err_oob                 sticky: an out-of-range index was accepted
module cover_toggle_collector
  import cover_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              hit_valid,
  input  logic [IDX_W-1:0]  hit_index,
  output logic              hit_ready,
  input  logic              clear_req,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WORD_W-1:0] dump_data,
  output logic              dump_last,
  output logic [IDX_W-1:0]  covered_cnt,
  output logic              new_hit,
  output logic              err_oob
);

  localparam int STAGES = 1;

  cov_state_t        state;
  logic [STAGES:0]   vld_pipe;     // [0] S1 read-modify-write, [1] count update
  hit_req_t          s0_req, s1_req;
  logic              s1_fwd;
  logic [WORD_W-1:0] s1_fwd_data;
  logic [ADDR_W-1:0] clr_ptr, dump_ptr;
  logic              dump_pend;    // dump read issued, data lands next cycle

  logic              accept;
  logic [WORD_W-1:0] s1_base, s1_wdata;
  logic              s1_we, s1_old, s1_first;
  logic              dump_rd;
  logic [ADDR_W-1:0] dump_rd_addr;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  // clear_req wins over a hit presented in the same cycle
  assign accept = hit_valid & hit_ready & ~clear_req;
  assign s0_req = decode_hit(hit_index);

  // S1: the RAM read misses the write made by the previous hit in the same
  // cycle, so a registered copy of that write is used instead.
  assign s1_base  = s1_fwd ? s1_fwd_data : ram_rdata;
  assign s1_old   = s1_base[s1_req.bsel];
  assign s1_wdata = s1_base | (WORD_W'(1) << s1_req.bsel);
  assign s1_we    = vld_pipe[0] & ~s1_req.oob;
  assign s1_first = s1_we & ~s1_old;

  // Dump reads: word 0 when the pipeline is empty, then the next word on
  // each accepted handshake.
  assign dump_rd = ~clear_req &
                   (((state == DRAIN) & (vld_pipe == '0)) |
                    ((state == DUMP) & ~dump_pend & dump_valid & dump_ready & ~dump_last));
  assign dump_rd_addr = (state == DRAIN) ? '0 : dump_ptr + ADDR_W'(1);

  assign ram_we    = (state == CLEAR) | s1_we;
  assign ram_waddr = (state == CLEAR) ? clr_ptr : s1_req.word;
  assign ram_wdata = (state == CLEAR) ? '0 : s1_wdata;
  assign ram_re    = (accept & ~s0_req.oob) | dump_rd;
  assign ram_raddr = dump_rd ? dump_rd_addr : s0_req.word;

  cover_bitmap_sdp_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Hit pipeline, counter and error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe    <= '0;
      s1_req      <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
      new_hit     <= 1'b0;
      covered_cnt <= '0;
      err_oob     <= 1'b0;
    end else begin
      vld_pipe    <= clear_req ? '0 : {vld_pipe[STAGES-1:0], accept};
      s1_req      <= s0_req;
      s1_fwd      <= s1_we & (s1_req.word == s0_req.word);
      s1_fwd_data <= s1_wdata;
      new_hit     <= s1_first & ~clear_req;
      if (clear_req || state == CLEAR) covered_cnt <= '0;
      else if (s1_first)               covered_cnt <= covered_cnt + IDX_W'(1);
      if (clear_req)                   err_oob <= 1'b0;
      else if (accept && s0_req.oob)   err_oob <= 1'b1;
    end
  end

  // Control FSM with registered hit_ready and dump outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      hit_ready  <= 1'b0;
      clr_ptr    <= '0;
      dump_ptr   <= '0;
      dump_pend  <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else if (clear_req) begin
      state      <= CLEAR;
      hit_ready  <= 1'b0;
      clr_ptr    <= '0;
      dump_pend  <= 1'b0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == ADDR_W'(NUM_WORDS - 1)) begin
            state     <= RUN;
            hit_ready <= 1'b1;
          end
        end
        RUN: begin
          if (dump_req) begin
            state     <= DRAIN;
            hit_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (vld_pipe == '0) begin
            state     <= DUMP;
            dump_ptr  <= dump_rd_addr;
            dump_pend <= 1'b1;
          end
        end
        DUMP: begin
          if (dump_pend) begin
            dump_pend  <= 1'b0;
            dump_valid <= 1'b1;
            dump_addr  <= dump_ptr;
            dump_data  <= ram_rdata;
            dump_last  <= (dump_ptr == ADDR_W'(NUM_WORDS - 1));
          end else if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (dump_last) begin
              state     <= RUN;
              hit_ready <= 1'b1;
            end else begin
              dump_ptr  <= dump_rd_addr;
              dump_pend <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
